apb_arb_master: RTL and testbench

- APB master controller that shares one APB bus between two requesters (req0, req1), e.g. a host-side register port and a debug/loader port.
- Arbitrates round-robin and runs the APB SETUP/ACCESS sequence, including PREADY wait states.
- Returns read data and slave error to the winning requester.
- Drives the master side of apb_intf (PSEL, PENABLE, PWRITE, PADDR, PWDATA) and samples PRDATA, PREADY, PSLVERR.

---
 rtl/apb_arb_pkg.sv | 21 ++
 rtl/apb_arb_master_rr_arb2.sv | 29 ++
 rtl/apb_arb_master.sv | 161 ++++++++++++++++
 tb/tb_apb_arb_master.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// ============================================================================
// Module   : apb_arb_pkg
// Brief    : Shared types and constants for the two-requester APB master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam int NUM_REQ            = 2;
   localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

`default_nettype wire

// File: rtl/apb_arb_master_rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin arbiter; combinational one-hot grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
   import apb_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_elig,
   input  logic               i_last_grant,
   output logic [NUM_REQ-1:0] o_gnt
);

   always_comb begin
      o_gnt = '0;
      case (i_elig)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         // On contention the requester not served last time wins.
         2'b11:   o_gnt = i_last_grant ? 2'b01 : 2'b10;
         default: o_gnt = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/apb_arb_master.sv
// ============================================================================
// Module   : apb_arb_master
// Brief    : APB master shared by two requesters with round-robin arbitration.
//            Optional ACCESS timeout enabled by macro APB_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_arb_master
   import apb_arb_pkg::*;
#(
   parameter int AWIDTH         = 4,
   parameter int DWIDTH         = 8,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [AWIDTH-1:0] req0_addr,
   input  logic [DWIDTH-1:0] req0_wdata,
   output logic              req0_ack,
   output logic [DWIDTH-1:0] req0_rdata,
   output logic              req0_err,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [AWIDTH-1:0] req1_addr,
   input  logic [DWIDTH-1:0] req1_wdata,
   output logic              req1_ack,
   output logic [DWIDTH-1:0] req1_rdata,
   output logic              req1_err,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [AWIDTH-1:0] PADDR,
   output logic [DWIDTH-1:0] PWDATA,
   input  logic [DWIDTH-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [NUM_REQ-1:0]  w_elig;
   logic [NUM_REQ-1:0]  w_gnt;
   logic [NUM_REQ-1:0]  r_ack;
   logic [NUM_REQ-1:0]  r_err;
   logic                r_gnt;
   logic                r_last;
   logic                w_done;
   logic                w_tmo;
   logic                r_pwrite;
   logic [AWIDTH-1:0]   r_paddr;
   logic [DWIDTH-1:0]   r_pwdata;
   logic [DWIDTH-1:0]   r_rdata0;
   logic [DWIDTH-1:0]   r_rdata1;
   logic [DWIDTH-1:0]   w_rdata;

   // A requester being acked this cycle must not be granted again on the same valid.
   assign w_elig = {req1_valid & ~r_ack[1], req0_valid & ~r_ack[0]};

   rr_arb2 u_rr_arb2 (
      .i_elig       (w_elig),
      .i_last_grant (r_last),
      .o_gnt        (w_gnt)
   );

   assign w_done  = (r_state == ACCESS) && PREADY;
   assign w_rdata = (w_done && !r_pwrite) ? PRDATA : '0;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int C_TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [C_TCNT_W-1:0] r_tcnt;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_tcnt <= '0;
      end else if (r_state == SETUP) begin
         r_tcnt <= '0;
      end else if ((r_state == ACCESS) && !PREADY) begin
         r_tcnt <= r_tcnt + 1'b1;
      end
   end

   assign w_tmo = (r_state == ACCESS) && !PREADY &&
                  (r_tcnt == C_TCNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
   assign w_tmo        = 1'b0;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (|w_elig) w_state_nxt = SETUP;
         SETUP:   w_state_nxt = ACCESS;
         ACCESS:  if (w_done || w_tmo) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_gnt    <= 1'b0;
         r_last   <= 1'b1;
         r_pwrite <= 1'b0;
         r_paddr  <= '0;
         r_pwdata <= '0;
         r_ack    <= '0;
         r_err    <= '0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         r_ack    <= '0;
         r_err    <= '0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
         if ((r_state == IDLE) && (|w_elig)) begin
            r_gnt    <= w_gnt[1];
            r_pwrite <= w_gnt[1] ? req1_write : req0_write;
            r_paddr  <= w_gnt[1] ? req1_addr  : req0_addr;
            r_pwdata <= w_gnt[1] ? req1_wdata : req0_wdata;
         end
         if (w_done || w_tmo) begin
            r_last       <= r_gnt;
            r_ack[r_gnt] <= 1'b1;
            r_err[r_gnt] <= w_tmo ? 1'b1 : PSLVERR;
            if (r_gnt) begin
               r_rdata1 <= w_rdata;
            end else begin
               r_rdata0 <= w_rdata;
            end
         end
      end
   end

   // PSEL/PENABLE decode straight from the state register so reset clears them at once.
   assign PSEL       = (r_state != IDLE);
   assign PENABLE    = (r_state == ACCESS);
   assign PWRITE     = r_pwrite;
   assign PADDR      = r_paddr;
   assign PWDATA     = r_pwdata;
   assign req0_ack   = r_ack[0];
   assign req1_ack   = r_ack[1];
   assign req0_err   = r_err[0];
   assign req1_err   = r_err[1];
   assign req0_rdata = r_rdata0;
   assign req1_rdata = r_rdata1;

endmodule

`default_nettype wire

// File: tb/tb_apb_arb_master.sv
// ============================================================================
// Module   : tb_apb_arb_master
// Brief    : Directed self-checking bench for apb_arb_master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_arb_master;

   logic       PCLK;
   logic       PRESETn;
   logic       req0_valid, req0_write, req1_valid, req1_write;
   logic [3:0] req0_addr, req1_addr;
   logic [7:0] req0_wdata, req1_wdata;
   logic       req0_ack, req0_err, req1_ack, req1_err;
   logic [7:0] req0_rdata, req1_rdata;
   logic       PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [3:0] PADDR;
   logic [7:0] PWDATA, PRDATA;

   int         total = 0;
   int         bad   = 0;
   int         cur_waits = 0;
   int         acc_cycles = 0;
   logic       slv_hold = 1'b0;
   logic [7:0] cur_prdata = 8'h00;
   logic       cur_slverr = 1'b0;

   apb_arb_master #(.AWIDTH(4), .DWIDTH(8), .TIMEOUT_CYCLES(16)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_rdata(req0_rdata),
      .req0_err(req0_err),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_rdata(req1_rdata),
      .req1_err(req1_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   // Slave model: PREADY rises after cur_waits ACCESS cycles unless held off.
   assign PREADY  = !slv_hold && (acc_cycles >= cur_waits);
   assign PRDATA  = cur_prdata;
   assign PSLVERR = cur_slverr;

   always @(posedge PCLK) begin
      if (PSEL && PENABLE && !PREADY) acc_cycles <= acc_cycles + 1;
      else                            acc_cycles <= 0;
   end

   typedef struct {
      logic       sel;
      logic       write;
      logic [3:0] addr;
      logic [7:0] wdata;
      int         waits;
      logic [7:0] prdata;
      logic       slverr;
      logic [7:0] exp_rdata;
      logic       exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic run_xfer(input vec_t v, input string nm);
      int  psel_cyc;
      int  en_cnt;
      int  lat;
      bit  acked;
      @(posedge PCLK); #1;
      cur_waits  = v.waits;
      cur_prdata = v.prdata;
      cur_slverr = v.slverr;
      if (v.sel) begin
         req1_valid = 1'b1; req1_write = v.write; req1_addr = v.addr; req1_wdata = v.wdata;
      end else begin
         req0_valid = 1'b1; req0_write = v.write; req0_addr = v.addr; req0_wdata = v.wdata;
      end
      psel_cyc = -1; en_cnt = 0; lat = 0; acked = 1'b0;
      for (int cyc = 1; cyc <= 64 && !acked; cyc++) begin
         @(posedge PCLK); #1;
         if (PSEL && psel_cyc < 0) begin
            psel_cyc = cyc;
            // Drop valid and scramble fields after grant; the transfer must still complete.
            req0_valid = 1'b0; req1_valid = 1'b0;
            req0_addr = ~v.addr; req1_addr = ~v.addr;
            req0_wdata = ~v.wdata; req1_wdata = ~v.wdata;
            req0_write = ~v.write; req1_write = ~v.write;
         end
         if (PENABLE) begin
            en_cnt++;
            chk({nm, "_paddr"}, 32'(PADDR), 32'(v.addr));
            chk({nm, "_pwrite"}, 32'(PWRITE), 32'(v.write));
            if (v.write) chk({nm, "_pwdata"}, 32'(PWDATA), 32'(v.wdata));
         end
         if (req0_ack || req1_ack) begin
            acked = 1'b1;
            lat = cyc;
            chk({nm, "_ack"}, 32'({req1_ack, req0_ack}), v.sel ? 32'h2 : 32'h1);
            chk({nm, "_rdata"}, 32'(v.sel ? req1_rdata : req0_rdata), 32'(v.exp_rdata));
            chk({nm, "_err"}, 32'(v.sel ? req1_err : req0_err), 32'(v.exp_err));
            chk({nm, "_psel_ack_cycle"}, 32'(PSEL), 32'h0);
         end
      end
      chk({nm, "_acked"}, 32'(acked), 32'h1);
      chk({nm, "_psel_latency"}, 32'(psel_cyc), 32'h1);
      chk({nm, "_enable_cycles"}, 32'(en_cnt), 32'(v.waits + 1));
      chk({nm, "_ack_latency"}, 32'(lat), 32'(v.waits + 3));
      @(posedge PCLK); #1;
      chk({nm, "_ack_single"}, 32'({req1_ack, req0_ack, req1_err, req0_err}), 32'h0);
      chk({nm, "_rdata_idle"}, 32'({req1_rdata, req0_rdata}), 32'h0);
   endtask

   task automatic contention(input int n, input string nm);
      int got;
      @(posedge PCLK); #1;
      cur_waits = 0; cur_slverr = 1'b0; slv_hold = 1'b0;
      req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 4'h1; req0_wdata = 8'h10;
      req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 4'h2; req1_wdata = 8'h20;
      got = 0;
      for (int c = 0; c < 16 * n && got < n; c++) begin
         @(posedge PCLK); #1;
         if (req0_ack || req1_ack) begin
            chk($sformatf("%s_grant%0d", nm, got), 32'({req1_ack, req0_ack}),
                (got % 2 == 1) ? 32'h2 : 32'h1);
            got++;
            if (got == n) begin
               req0_valid = 1'b0; req1_valid = 1'b0;
            end
         end
      end
      chk({nm, "_count"}, 32'(got), 32'(n));
      repeat (4) @(posedge PCLK);
      #1;
      chk({nm, "_quiet"}, 32'({PSEL, req1_ack, req0_ack}), 32'h0);
   endtask

   initial begin
      bit found;
      //          sel   wr    addr   wdata  wt prdata slv   exp_rd exp_err
      vecs[0] = '{1'b0, 1'b1, 4'h3, 8'hA5, 0, 8'h77, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 4'h5, 8'h00, 3, 8'h3C, 1'b0, 8'h3C, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 4'hF, 8'h5A, 0, 8'h00, 1'b1, 8'h00, 1'b1};
      vecs[3] = '{1'b0, 1'b0, 4'h0, 8'h00, 0, 8'hC3, 1'b0, 8'hC3, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 4'h9, 8'h11, 1, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 4'hA, 8'h00, 2, 8'hFF, 1'b1, 8'hFF, 1'b1};

      PRESETn = 1'b0;
      req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
      repeat (2) @(posedge PCLK);
      #1;
      chk("rst_psel_penable", 32'({PSEL, PENABLE}), 32'h0);
      chk("rst_pwrite_paddr_pwdata", 32'({PWRITE, PADDR, PWDATA}), 32'h0);
      chk("rst_acks_errs", 32'({req1_ack, req0_ack, req1_err, req0_err}), 32'h0);
      chk("rst_rdata", 32'({req1_rdata, req0_rdata}), 32'h0);
      @(negedge PCLK);
      PRESETn = 1'b1;

      for (int i = 0; i < 6; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

      contention(4, "cont4");

      // Leave last_grant at req0 so only a correct reset restores req0 priority.
      run_xfer(vecs[0], "pre_rst");

      @(posedge PCLK); #1;
      slv_hold = 1'b1;
      req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 4'h6; req0_wdata = 8'h00;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(posedge PCLK); #1;
         if (PSEL) req0_valid = 1'b0;
         if (PENABLE) found = 1'b1;
      end
      chk("midrst_reached_access", 32'(found), 32'h1);
      #2;
      PRESETn = 1'b0;
      #1;
      chk("midrst_async_drop", 32'({PSEL, PENABLE}), 32'h0);
      chk("midrst_paddr", 32'(PADDR), 32'h0);
      repeat (2) begin
         @(posedge PCLK); #1;
         chk("midrst_no_ack", 32'({req1_ack, req0_ack}), 32'h0);
      end
      @(negedge PCLK);
      PRESETn = 1'b1;
      slv_hold = 1'b0;
      contention(2, "post_rst");

`ifdef APB_ARB_TIMEOUT_EN
      begin
         int  en_cnt;
         bit  acked;
         @(posedge PCLK); #1;
         slv_hold = 1'b1; cur_prdata = 8'hEE;
         req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 4'h2;
         en_cnt = 0; acked = 1'b0;
         for (int c = 0; c < 64 && !acked; c++) begin
            @(posedge PCLK); #1;
            if (PSEL) req0_valid = 1'b0;
            if (PENABLE) en_cnt++;
            if (req0_ack || req1_ack) begin
               acked = 1'b1;
               chk("tmo_ack", 32'({req1_ack, req0_ack}), 32'h1);
               chk("tmo_err", 32'(req0_err), 32'h1);
               chk("tmo_rdata", 32'(req0_rdata), 32'h0);
               chk("tmo_psel", 32'(PSEL), 32'h0);
            end
         end
         chk("tmo_seen", 32'(acked), 32'h1);
         chk("tmo_access_cycles", 32'(en_cnt), 32'd16);
         slv_hold = 1'b0;
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
